// File: rtl/udp_hdr_parser.sv
// rtl/udp_hdr_parser.sv - UDP header parser with payload forwarding and port filter.
// Optional UDP_LEN_CHECK_EN adds payload word counting against udp_len.
module udp_hdr_parser #(
    parameter logic [15:0] PORT_FILTER = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_valid,
    output logic        r_ready,
    input  logic [15:0] r_data,
    input  logic        r_last,
    output logic        t_valid,
    input  logic        t_ready,
    output logic [15:0] t_data,
    output logic        t_last,
    output logic        hdr_valid,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_len,
    output logic [15:0] udp_csum,
    output logic        err_short,
    output logic        err_len
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  wcnt, wcnt_nxt;
    logic [15:0] sh_src, sh_dst, sh_len;
    logic        hs, load, xfer;
    logic        hdr_hs, word3_hs, filt_miss, len_bad;

    assign hs        = r_valid && r_ready;
    assign hdr_hs    = hs && (state == HDR);
    assign word3_hs  = hdr_hs && (wcnt == 2'd3);
    assign load      = hs && (state == PAYLOAD);
    assign xfer      = t_valid && t_ready;
    assign filt_miss = (PORT_FILTER != 16'h0000) && (sh_dst != PORT_FILTER);

    always_comb begin
        r_ready = 1'b0;
        if (rst_n) begin
            r_ready = (state == PAYLOAD) ? (!t_valid || t_ready) : 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            HDR: begin
                if (hs) begin
                    if (wcnt == 2'd3) begin
                        wcnt_nxt = 2'd0;
                        // A datagram that ends on its last header word must not swallow the next one
                        if (r_last)
                            state_nxt = HDR;
                        else if (filt_miss || len_bad)
                            state_nxt = DROP;
                        else
                            state_nxt = PAYLOAD;
                    end else if (r_last) begin
                        wcnt_nxt = 2'd0;
                    end else begin
                        wcnt_nxt = wcnt + 2'd1;
                    end
                end
            end
            PAYLOAD: if (hs && r_last) state_nxt = HDR;
            DROP:    if (hs && r_last) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HDR;
            wcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Words 0..2 go to shadows so the visible fields only change together at word 3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_src    <= 16'h0000;
            sh_dst    <= 16'h0000;
            sh_len    <= 16'h0000;
            src_port  <= 16'h0000;
            dst_port  <= 16'h0000;
            udp_len   <= 16'h0000;
            udp_csum  <= 16'h0000;
            hdr_valid <= 1'b0;
            err_short <= 1'b0;
        end else begin
            hdr_valid <= word3_hs;
            err_short <= hdr_hs && (wcnt != 2'd3) && r_last;
            if (hdr_hs) begin
                case (wcnt)
                    2'd0: sh_src <= r_data;
                    2'd1: sh_dst <= r_data;
                    2'd2: sh_len <= r_data;
                    default: begin
                        src_port <= sh_src;
                        dst_port <= sh_dst;
                        udp_len  <= sh_len;
                        udp_csum <= r_data;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            t_data  <= 16'h0000;
            t_last  <= 1'b0;
        end else if (load) begin
            t_valid <= 1'b1;
            t_data  <= r_data;
            t_last  <= r_last;
        end else if (xfer) begin
            t_valid <= 1'b0;
        end
    end

`ifdef UDP_LEN_CHECK_EN
    logic [15:0] pcnt, pcnt_inc;
    logic [16:0] exp_cnt;

    assign len_bad  = (sh_len < 16'd8);
    assign pcnt_inc = pcnt + 16'd1;
    // (udp_len - 8 + 1) >> 1 rounds odd byte counts up to whole words
    assign exp_cnt  = ({1'b0, udp_len} - 17'd7) >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt    <= 16'h0000;
            err_len <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (word3_hs) begin
                pcnt    <= 16'h0000;
                err_len <= len_bad;
            end else if (load) begin
                pcnt <= pcnt_inc;
                if (r_last && ({1'b0, pcnt_inc} != exp_cnt))
                    err_len <= 1'b1;
            end
        end
    end
`else
    assign len_bad = 1'b0;
    assign err_len = 1'b0;
`endif

endmodule
